mips_hazard_frontend: RTL and testbench
=======================================

Name: mips_hazard_frontend

Overview:
Parametrised IF/ID/EX front-end for the pipelined MIPS core with load-use hazard detection. Generalises the single-cycle load-use interlock to loads of configurable latency (LOAD_LAT stages tracked past ID), adds valid bits, an EX-originated flush, an upstream ready handshake and a saturating stall counter. It sits between instruction fetch and the EX datapath, driving the ID instruction and the ID/EX control registers.

Parameters:
INSTR_W, 32, instruction width; must be >= 32 (MIPS field positions fixed at [31:0])
REG_AW, 5, register-address width of rs/rt fields (rs = instr[25:21], rt = instr[20:16] when 5)
LOAD_LAT, 1, pipeline stages after ID during which a load result is unavailable; range 1..4
OP_LOAD, 6'h23, opcode decoded as a memory read
ZERO_EXEMPT, 1, 1 = register 0 never causes a hazard
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
if_instr  in  INSTR_W  fetched instruction
if_valid  in  1  if_instr is valid this cycle
if_ready  out  1  front-end accepts if_instr this cycle (= ~stall)
flush  in  1  branch/jump taken in EX; squash ID
id_instr  out  INSTR_W  instruction held in ID
id_valid  out  1  id_instr is valid
ex_valid  out  1  EX stage holds a real instruction
ex_memread  out  1  EX instruction is a load
ex_rt  out  REG_AW  EX instruction rt field
stall  out  1  combinational load-use stall
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (reset=0, asynchronous): id_instr=0, id_valid=0, all tracker entries (valid, memread, rt)=0, stall_count=0; hence ex_valid=0, ex_memread=0, ex_rt=0, stall=0, if_ready=1. Reset mid-stall drops everything immediately.
- Decode in ID: memread_id = (id_instr[31:26]==OP_LOAD); rs/rt from fixed fields.
- Load tracker: shift register of LOAD_LAT entries {valid, memread, rt}; entry 0 is the ID/EX register, exported as ex_*. Entry k+1 <= entry k every cycle (never stalls).
- Hazard term per entry k: valid && memread && (rt==id_rs || rt==id_rt) && !(ZERO_EXEMPT && rt==0).
- stall = id_valid && !flush && OR of hazard terms. Purely combinational from registers and flush; no combinational path from if_*.
- Per rising edge, priority flush > stall > advance:
  flush=1: id_valid<=0 (id_instr don't-care, hold); entry0<=bubble {0,0,0}.
  stall=1: ID holds id_instr/id_valid; entry0<=bubble; if_instr not consumed.
  else: id_instr<=if_instr, id_valid<=if_valid; entry0<={id_valid, memread_id&id_valid, id_rt}.
- if_valid=0 in advance cycle loads a bubble into ID (id_valid=0).
- Latency: instruction accepted at edge N is in ID after N, EX after N+1 (no stall). A dependent instruction directly behind a load stalls exactly LOAD_LAT cycles; one behind by j (j<LOAD_LAT) instructions stalls LOAD_LAT-j cycles.
- stall_count increments on each edge with stall=1; saturates at all-ones, never wraps.
- LOAD_LAT=1 reproduces the classic single-cycle interlock exactly.

Decomposition:
- Shared package mips_pkg: opcode constants (OP_LOAD, OP_STORE, OP_RTYPE), field position constants, tracker-entry struct/typedef {valid, memread, rt}.
- One sub-module natural: mips_load_tracker (LOAD_LAT-deep entry shift register + hazard OR-reduction); the top keeps the ID register, priority logic and counter.

Test Plan:
- LOAD_LAT=1: issue lw $2,0($1) (0x8C220000) then add $3,$2,$4 (0x00441820) -> stall=1 for exactly 1 cycle, ex_valid=0 bubble, add enters EX next cycle, stall_count=1.
- LOAD_LAT=3: same pair -> 3 stall cycles; with one independent instr (0x00A63820) between, 2 stall cycles; stall_count=5 total.
- ZERO_EXEMPT=1: lw $0,0($1) (0x8C200000) then add $3,$0,$4 -> no stall; ZERO_EXEMPT=0 -> 1 stall.
- Flush during stall: lw/add hazard with flush=1 in the stall cycle -> stall=0 that cycle, id_valid=0 after edge, ex_valid=0, fetch resumes (if_ready=1).
- Assert reset low mid-stall (asynchronous, between edges) -> all outputs zero immediately, if_ready=1; after release, no residual stall.
- Force 2^CNT_W+3 stall cycles with CNT_W=4 -> stall_count holds 4'hF, no wrap.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and the load-tracker entry layout.
// rt is carried zero-extended to REG_AW_MAX bits so one entry type serves every REG_AW.
package mips_pkg;
   localparam logic [5:0] OPC_LOAD  = 6'h23;
   localparam logic [5:0] OPC_STORE = 6'h2B;
   localparam logic [5:0] OPC_RTYPE = 6'h00;

   localparam int OPC_LSB = 26;
   localparam int OPC_W   = 6;
   localparam int RS_LSB  = 21;
   localparam int RT_LSB  = 16;

   localparam int REG_AW_MAX = 8;

   typedef struct packed {
      logic                  valid;
      logic                  memread;
      logic [REG_AW_MAX-1:0] rt;
   } trk_entry_t;
endpackage

// File: rtl/mips_load_tracker.sv
// LOAD_LAT-deep shift register of instructions past ID, flagging loads whose result ID still needs.
// Entry 0 is the ID/EX register; the chain advances every cycle and never stalls.
module mips_load_tracker
   import mips_pkg::*;
#(
   parameter int REG_AW      = 5,
   parameter int LOAD_LAT    = 1,
   parameter bit ZERO_EXEMPT = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  trk_entry_t        ent0_nxt,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   output logic              hazard,
   output logic              ex_valid,
   output logic              ex_memread,
   output logic [REG_AW-1:0] ex_rt
);
   trk_entry_t ent [LOAD_LAT];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < LOAD_LAT; k++) ent[k] <= '0;
      end else begin
         ent[0] <= ent0_nxt;
         for (int k = 1; k < LOAD_LAT; k++) ent[k] <= ent[k-1];
      end
   end

   // Any in-flight load whose destination ID reads; register 0 optionally never hazards.
   always_comb begin
      hazard = 1'b0;
      for (int k = 0; k < LOAD_LAT; k++) begin
         if (ent[k].valid && ent[k].memread &&
             (ent[k].rt == REG_AW_MAX'(id_rs) || ent[k].rt == REG_AW_MAX'(id_rt)) &&
             !(ZERO_EXEMPT && ent[k].rt == '0))
            hazard = 1'b1;
      end
   end

   assign ex_valid   = ent[0].valid;
   assign ex_memread = ent[0].memread;
   assign ex_rt      = ent[0].rt[REG_AW-1:0];
endmodule

// File: rtl/mips_hazard_frontend.sv
// IF/ID/EX front-end: ID register with flush > stall > advance priority, load-use interlock, stall counter.
// One cycle IF->ID and ID->EX; if_ready drops (if_instr not consumed) while a load-use hazard holds ID.
module mips_hazard_frontend
   import mips_pkg::*;
#(
   parameter int         INSTR_W     = 32,
   parameter int         REG_AW      = 5,
   parameter int         LOAD_LAT    = 1,
   parameter logic [5:0] OP_LOAD     = OPC_LOAD,
   parameter bit         ZERO_EXEMPT = 1'b1,
   parameter int         CNT_W       = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] if_instr,
   input  logic               if_valid,
   output logic               if_ready,
   input  logic               flush,
   output logic [INSTR_W-1:0] id_instr,
   output logic               id_valid,
   output logic               ex_valid,
   output logic               ex_memread,
   output logic [REG_AW-1:0]  ex_rt,
   output logic               stall,
   output logic [CNT_W-1:0]   stall_count
);
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              memread_id;
   logic              hazard;
   trk_entry_t        ent0_nxt;

   assign id_rs      = id_instr[RS_LSB +: REG_AW];
   assign id_rt      = id_instr[RT_LSB +: REG_AW];
   assign memread_id = (id_instr[OPC_LSB +: OPC_W] == OP_LOAD);

   assign stall    = id_valid && !flush && hazard;
   assign if_ready = !stall;

   // Flush and stall both send a bubble into EX; only a clean advance issues the ID instruction.
   always_comb begin
      ent0_nxt = '0;
      if (!flush && !stall) begin
         ent0_nxt.valid   = id_valid;
         ent0_nxt.memread = memread_id && id_valid;
         ent0_nxt.rt      = REG_AW_MAX'(id_rt);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         id_instr    <= '0;
         id_valid    <= 1'b0;
         stall_count <= '0;
      end else begin
         if (flush) begin
            id_valid <= 1'b0;
         end else if (!stall) begin
            id_instr <= if_instr;
            id_valid <= if_valid;
         end
         if (stall && stall_count != '1)
            stall_count <= stall_count + CNT_W'(1);
      end
   end

   mips_load_tracker #(
      .REG_AW      (REG_AW),
      .LOAD_LAT    (LOAD_LAT),
      .ZERO_EXEMPT (ZERO_EXEMPT)
   ) u_tracker (
      .clk        (clk),
      .reset      (reset),
      .ent0_nxt   (ent0_nxt),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .hazard     (hazard),
      .ex_valid   (ex_valid),
      .ex_memread (ex_memread),
      .ex_rt      (ex_rt)
   );
endmodule

// File: tb/tb_mips_hazard_frontend.sv
// Bench for mips_hazard_frontend: instance 0 is LOAD_LAT=1/ZERO_EXEMPT=0/CNT_W=4,
// instance 1 is LOAD_LAT=3/ZERO_EXEMPT=1/CNT_W=16; a timestamp-based model tracks both.
module tb_mips_hazard_frontend;
   localparam logic [31:0] LW22  = 32'h8C220000;   // lw  $2,0($1)
   localparam logic [31:0] ADD   = 32'h00441820;   // add $3,$2,$4
   localparam logic [31:0] INDEP = 32'h00A63820;   // add $7,$5,$6
   localparam logic [31:0] LW0   = 32'h8C200000;   // lw  $0,0($1)
   localparam logic [31:0] ADD0  = 32'h00041820;   // add $3,$0,$4
   localparam logic [31:0] LWCH  = 32'h8C420000;   // lw  $2,0($2)

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] if_instr [2];
   logic        if_valid [2];
   logic        flush    [2];
   logic [31:0] id_instr [2];
   logic        if_ready [2];
   logic        id_valid [2];
   logic        ex_valid [2];
   logic        ex_memread [2];
   logic        stall    [2];
   logic [4:0]  ex_rt    [2];
   logic [3:0]  cnt_a;
   logic [15:0] cnt_b;
   logic [15:0] cnt [2];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign cnt[0] = {12'd0, cnt_a};
   assign cnt[1] = cnt_b;

   mips_hazard_frontend #(.LOAD_LAT(1), .ZERO_EXEMPT(1'b0), .CNT_W(4)) dut_a (
      .clk(clk), .reset(reset), .if_instr(if_instr[0]), .if_valid(if_valid[0]),
      .if_ready(if_ready[0]), .flush(flush[0]), .id_instr(id_instr[0]), .id_valid(id_valid[0]),
      .ex_valid(ex_valid[0]), .ex_memread(ex_memread[0]), .ex_rt(ex_rt[0]), .stall(stall[0]),
      .stall_count(cnt_a));

   mips_hazard_frontend #(.LOAD_LAT(3), .ZERO_EXEMPT(1'b1), .CNT_W(16)) dut_b (
      .clk(clk), .reset(reset), .if_instr(if_instr[1]), .if_valid(if_valid[1]),
      .if_ready(if_ready[1]), .flush(flush[1]), .id_instr(id_instr[1]), .id_valid(id_valid[1]),
      .ex_valid(ex_valid[1]), .ex_memread(ex_memread[1]), .ex_rt(ex_rt[1]), .stall(stall[1]),
      .stall_count(cnt_b));

   // Reference model: last_ld[i][r] is the cycle a load writing r entered EX; it blocks
   // a reader in ID while its age is 1..LOAD_LAT cycles.
   int          cyc = 0;
   int          last_ld [2][32];
   logic [31:0] m_instr [2];
   logic        m_v [2];
   logic        m_exv [2];
   logic        m_exm [2];
   logic [4:0]  m_exrt [2];
   int          m_cnt [2];

   function automatic int lat(int i);    return (i == 0) ? 1 : 3;      endfunction
   function automatic int cmax(int i);   return (i == 0) ? 15 : 65535; endfunction
   function automatic bit exempt(int i); return i == 1;                endfunction

   function automatic bit m_stall(int i);
      logic [31:0] w;
      int rs, rt;
      bit h;
      w  = m_instr[i];
      rs = int'(w[25:21]);
      rt = int'(w[20:16]);
      h  = 1'b0;
      if (cyc - last_ld[i][rs] <= lat(i) && !(exempt(i) && rs == 0)) h = 1'b1;
      if (cyc - last_ld[i][rt] <= lat(i) && !(exempt(i) && rt == 0)) h = 1'b1;
      return m_v[i] && !flush[i] && h;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            m_instr[i] <= '0; m_v[i] <= 1'b0; m_cnt[i] <= 0;
            m_exv[i] <= 1'b0; m_exm[i] <= 1'b0; m_exrt[i] <= '0;
            for (int r = 0; r < 32; r++) last_ld[i][r] <= -100;
         end
      end else begin
         cyc <= cyc + 1;
         for (int i = 0; i < 2; i++) begin
            if (flush[i] || m_stall(i)) begin
               m_exv[i] <= 1'b0; m_exm[i] <= 1'b0; m_exrt[i] <= '0;
               if (flush[i]) m_v[i] <= 1'b0;
               else if (m_cnt[i] < cmax(i)) m_cnt[i] <= m_cnt[i] + 1;
            end else begin
               m_exv[i]  <= m_v[i];
               m_exm[i]  <= m_v[i] && m_instr[i][31:26] == 6'h23;
               m_exrt[i] <= m_instr[i][20:16];
               if (m_v[i] && m_instr[i][31:26] == 6'h23) last_ld[i][int'(m_instr[i][20:16])] <= cyc;
               m_instr[i] <= if_instr[i];
               m_v[i]     <= if_valid[i];
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(int i, logic [31:0] ins, logic v, logic f);
      if_instr[i] = ins; if_valid[i] = v; flush[i] = f;
   endtask

   task automatic idle();
      put(0, '0, 1'b0, 1'b0);
      put(1, '0, 1'b0, 1'b0);
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [5:0] op;
      logic [4:0] rs, rt;
      case ($urandom_range(0, 2))
         0:       op = 6'h23;
         1:       op = 6'h00;
         default: op = 6'h2B;
      endcase
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      return {op, rs, rt, 16'($urandom)};
   endfunction

   task automatic test_reset();
      idle();
      #2 reset = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         checks += 7;
         if (stall[i] !== 1'b0) begin errors++; $display("FAIL reset_stall[%0d] got %b want 0", i, stall[i]); end
         if (if_ready[i] !== 1'b1) begin errors++; $display("FAIL reset_if_ready[%0d] got %b want 1", i, if_ready[i]); end
         if (id_valid[i] !== 1'b0 || id_instr[i] !== 32'd0) begin errors++; $display("FAIL reset_id[%0d] got v=%b %h want 0", i, id_valid[i], id_instr[i]); end
         if (ex_valid[i] !== 1'b0) begin errors++; $display("FAIL reset_ex_valid[%0d] got %b want 0", i, ex_valid[i]); end
         if (ex_memread[i] !== 1'b0) begin errors++; $display("FAIL reset_ex_memread[%0d] got %b want 0", i, ex_memread[i]); end
         if (ex_rt[i] !== 5'd0) begin errors++; $display("FAIL reset_ex_rt[%0d] got %0d want 0", i, ex_rt[i]); end
         if (cnt[i] !== 16'd0) begin errors++; $display("FAIL reset_count[%0d] got %0d want 0", i, cnt[i]); end
      end
      #5 reset = 1'b1;
      tick();
   endtask

   task automatic test_interlock_ll1();
      put(0, LW22, 1'b1, 1'b0); tick();
      put(0, ADD, 1'b1, 1'b0); tick();
      checks += 4;
      if (stall[0] !== 1'b1) begin errors++; $display("FAIL ll1_stall got %b want 1", stall[0]); end
      if (if_ready[0] !== 1'b0) begin errors++; $display("FAIL ll1_if_ready got %b want 0", if_ready[0]); end
      if (ex_memread[0] !== 1'b1) begin errors++; $display("FAIL ll1_ex_memread got %b want 1", ex_memread[0]); end
      if (ex_rt[0] !== 5'd2) begin errors++; $display("FAIL ll1_ex_rt got %0d want 2", ex_rt[0]); end
      tick();
      checks += 4;
      if (stall[0] !== 1'b0) begin errors++; $display("FAIL ll1_stall_end got %b want 0", stall[0]); end
      if (ex_valid[0] !== 1'b0) begin errors++; $display("FAIL ll1_bubble got %b want 0", ex_valid[0]); end
      if (id_valid[0] !== 1'b1 || id_instr[0] !== ADD) begin errors++; $display("FAIL ll1_id_hold got %b %h want 1 %h", id_valid[0], id_instr[0], ADD); end
      if (cnt[0] !== 16'd1) begin errors++; $display("FAIL ll1_count got %0d want 1", cnt[0]); end
      put(0, '0, 1'b0, 1'b0); tick();
      checks += 1;
      if (ex_valid[0] !== 1'b1 || ex_memread[0] !== 1'b0 || ex_rt[0] !== 5'd4) begin
         errors++; $display("FAIL ll1_add_in_ex got v=%b m=%b rt=%0d want 1 0 4", ex_valid[0], ex_memread[0], ex_rt[0]);
      end
   endtask

   task automatic test_interlock_ll3();
      int n;
      put(1, LW22, 1'b1, 1'b0); tick();
      put(1, ADD, 1'b1, 1'b0); tick();
      n = 0;
      for (int k = 0; k < 10 && stall[1] === 1'b1; k++) begin n++; tick(); end
      put(1, '0, 1'b0, 1'b0);
      checks += 1;
      if (n != 3) begin errors++; $display("FAIL ll3_adjacent_stalls got %0d want 3", n); end
      repeat (4) tick();
      put(1, LW22, 1'b1, 1'b0); tick();
      put(1, INDEP, 1'b1, 1'b0); tick();
      put(1, ADD, 1'b1, 1'b0); tick();
      n = 0;
      for (int k = 0; k < 10 && stall[1] === 1'b1; k++) begin n++; tick(); end
      put(1, '0, 1'b0, 1'b0);
      checks += 2;
      if (n != 2) begin errors++; $display("FAIL ll3_gap1_stalls got %0d want 2", n); end
      if (cnt[1] !== 16'd5) begin errors++; $display("FAIL ll3_count got %0d want 5", cnt[1]); end
      repeat (4) tick();
   endtask

   task automatic test_zero_reg();
      put(0, LW0, 1'b1, 1'b0); put(1, LW0, 1'b1, 1'b0); tick();
      put(0, ADD0, 1'b1, 1'b0); put(1, ADD0, 1'b1, 1'b0); tick();
      put(1, '0, 1'b0, 1'b0);
      checks += 2;
      if (stall[0] !== 1'b1) begin errors++; $display("FAIL zero_not_exempt got %b want 1", stall[0]); end
      if (stall[1] !== 1'b0) begin errors++; $display("FAIL zero_exempt got %b want 0", stall[1]); end
      tick();
      put(0, '0, 1'b0, 1'b0);
      checks += 2;
      if (stall[0] !== 1'b0) begin errors++; $display("FAIL zero_stall_len got %b want 0", stall[0]); end
      if (cnt[0] !== 16'd2 || cnt[1] !== 16'd5) begin errors++; $display("FAIL zero_counts got %0d %0d want 2 5", cnt[0], cnt[1]); end
      repeat (4) tick();
   endtask

   task automatic test_flush_in_stall();
      put(0, LW22, 1'b1, 1'b0); tick();
      put(0, ADD, 1'b1, 1'b0); tick();
      put(0, ADD, 1'b1, 1'b1);
      #1;
      checks += 2;
      if (stall[0] !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall[0]); end
      if (if_ready[0] !== 1'b1) begin errors++; $display("FAIL flush_if_ready got %b want 1", if_ready[0]); end
      tick();
      put(0, '0, 1'b0, 1'b0);
      #1;
      checks += 3;
      if (id_valid[0] !== 1'b0) begin errors++; $display("FAIL flush_id_valid got %b want 0", id_valid[0]); end
      if (ex_valid[0] !== 1'b0 || if_ready[0] !== 1'b1) begin errors++; $display("FAIL flush_ex_ready got ex=%b rdy=%b want 0 1", ex_valid[0], if_ready[0]); end
      if (cnt[0] !== 16'd2) begin errors++; $display("FAIL flush_count got %0d want 2", cnt[0]); end
      repeat (3) tick();
   endtask

   task automatic test_async_reset();
      put(1, LW22, 1'b1, 1'b0); tick();
      put(1, ADD, 1'b1, 1'b0); tick();
      checks += 1;
      if (stall[1] !== 1'b1) begin errors++; $display("FAIL areset_pre_stall got %b want 1", stall[1]); end
      #3 reset = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         checks += 3;
         if (stall[i] !== 1'b0 || if_ready[i] !== 1'b1) begin errors++; $display("FAIL areset_stall[%0d] got %b rdy=%b want 0 1", i, stall[i], if_ready[i]); end
         if (id_valid[i] !== 1'b0 || ex_valid[i] !== 1'b0 || ex_memread[i] !== 1'b0 || ex_rt[i] !== 5'd0 || id_instr[i] !== 32'd0) begin
            errors++; $display("FAIL areset_state[%0d] got id=%b/%h ex=%b/%b/%0d want zeros", i, id_valid[i], id_instr[i], ex_valid[i], ex_memread[i], ex_rt[i]);
         end
         if (cnt[i] !== 16'd0) begin errors++; $display("FAIL areset_count[%0d] got %0d want 0", i, cnt[i]); end
      end
      #2 reset = 1'b1;
      idle();
      tick();
      checks += 1;
      if (stall[1] !== 1'b0 || id_valid[1] !== 1'b0) begin errors++; $display("FAIL areset_residual got stall=%b idv=%b want 0 0", stall[1], id_valid[1]); end
   endtask

   task automatic test_saturation();
      int n, want;
      n = 0;
      put(0, LWCH, 1'b1, 1'b0);
      for (int k = 0; k < 60; k++) begin
         if (stall[0] === 1'b1) n++;
         tick();
         want = (n > 15) ? 15 : n;
         checks += 1;
         if (cnt[0] !== 16'(want)) begin errors++; $display("FAIL sat_count_step%0d got %0d want %0d", k, cnt[0], want); end
      end
      put(0, '0, 1'b0, 1'b0);
      checks += 2;
      if (n < 19) begin errors++; $display("FAIL sat_stall_cycles got %0d want >=19", n); end
      if (cnt_a !== 4'hF) begin errors++; $display("FAIL sat_hold got %h want f", cnt_a); end
      repeat (3) tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 2; i++)
            put(i, rnd_instr(), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
         #1;
         for (int i = 0; i < 2; i++) begin
            checks += 7;
            if (stall[i] !== m_stall(i)) begin errors++; $display("FAIL rnd_stall[%0d] c%0d got %b want %b", i, c, stall[i], m_stall(i)); end
            if (if_ready[i] !== !m_stall(i)) begin errors++; $display("FAIL rnd_if_ready[%0d] c%0d got %b want %b", i, c, if_ready[i], !m_stall(i)); end
            if (id_valid[i] !== m_v[i]) begin errors++; $display("FAIL rnd_id_valid[%0d] c%0d got %b want %b", i, c, id_valid[i], m_v[i]); end
            if (m_v[i] && id_instr[i] !== m_instr[i]) begin errors++; $display("FAIL rnd_id_instr[%0d] c%0d got %h want %h", i, c, id_instr[i], m_instr[i]); end
            if (ex_valid[i] !== m_exv[i] || ex_memread[i] !== m_exm[i]) begin
               errors++; $display("FAIL rnd_ex[%0d] c%0d got %b/%b want %b/%b", i, c, ex_valid[i], ex_memread[i], m_exv[i], m_exm[i]);
            end
            if (m_exv[i] && ex_rt[i] !== m_exrt[i]) begin errors++; $display("FAIL rnd_ex_rt[%0d] c%0d got %0d want %0d", i, c, ex_rt[i], m_exrt[i]); end
            if (cnt[i] !== 16'(m_cnt[i])) begin errors++; $display("FAIL rnd_count[%0d] c%0d got %0d want %0d", i, c, cnt[i], m_cnt[i]); end
         end
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_interlock_ll1();
      test_interlock_ll3();
      test_zero_reg();
      test_flush_in_stall();
      test_async_reset();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
